memstream_ramb_reader: RTL and testbench

- Parametrised successor to the dual-port, output-registered weight BRAM.
- One port is a host/config write port. The other is an autonomous sequential reader that streams a programmable window [base, base+len) onto an AXI-Stream master with full backpressure.
- Supports one-shot and loop modes and sustains 1 word/cycle with no bubbles.
- Sits between weight-memory init/config logic and the MVAU weight input inside memstream.

---
 rtl/memstream_ramb_reader.sv | 178 +++++++++++++++++
 tb/tb_memstream_ramb_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memstream_ramb_reader.sv
// Dual-port weight memory with an autonomous windowed reader that streams
// [base, base+len) onto an AXI-Stream master, one-shot or looping.
module memstream_ramb_reader #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 10,
  parameter int DEPTH      = 2**AWIDTH,
  parameter     MEM_INIT   = "",
  parameter     RAM_STYLE  = "auto",
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              cfg_we,
  input  logic [AWIDTH-1:0] cfg_addr,
  input  logic [DWIDTH-1:0] cfg_wdata,
  input  logic [AWIDTH-1:0] cfg_base,
  input  logic [AWIDTH:0]   cfg_len,
  input  logic              cfg_loop,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
  localparam logic [FAW+1:0]    FIFO_CAP  = (FAW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] base_q, base_d, rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   len_m1_q, len_m1_d, cnt_q, cnt_d;
  logic              loop_q, loop_d, done_q, done_d;
  logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [FAW-1:0]    fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [FAW:0]      fifo_cnt_q, fifo_cnt_d;
  logic [DWIDTH-1:0] s1_data_q, s2_data_q;
  logic              issue, is_last, push, pop;
  logic [FAW+1:0]    occupancy;

  (* ram_style = RAM_STYLE *) logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];

  // Credit covers both read stages so the FIFO can never be overrun.
  assign occupancy = (FAW+2)'(fifo_cnt_q) + (FAW+2)'(s1_valid_q) + (FAW+2)'(s2_valid_q);
  assign push      = s2_valid_q;
  assign pop       = m_axis_tvalid && m_axis_tready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    base_d     = base_q;
    len_m1_d   = len_m1_q;
    loop_d     = loop_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    is_last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && cfg_len != '0) begin
          state_d  = S_RUN;
          base_d   = cfg_base;
          len_m1_d = cfg_len - (AWIDTH+1)'(1);
          loop_d   = cfg_loop;
          rd_ptr_d = cfg_base;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        if (stop && loop_q) begin
          state_d = S_DRAIN;
        end else if (occupancy < FIFO_CAP) begin
          issue    = 1'b1;
          is_last  = (cnt_q == len_m1_q);
          rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + AWIDTH'(1);
          cnt_d    = cnt_q + (AWIDTH+1)'(1);
          if (is_last) begin
            if (loop_q) begin
              cnt_d    = '0;
              rd_ptr_d = base_q;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q && fifo_cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    s1_valid_d = issue;
    s1_last_d  = is_last;
    s2_valid_d = s1_valid_q;
    s2_last_d  = s1_last_q;

    fifo_wr_d  = push ? fifo_wr_q + FAW'(1) : fifo_wr_q;
    fifo_rd_d  = pop  ? fifo_rd_q + FAW'(1) : fifo_rd_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (FAW+1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (FAW+1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_m1_q   <= '0;
      loop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_m1_q   <= len_m1_d;
      loop_q     <= loop_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // NOTE: storage arrays and data registers carry no reset; their valid tags do.
  always_ff @(posedge clk) begin
    if (cfg_we) mem[cfg_addr] <= cfg_wdata;
  end

  // Separate read process on the same edge sees pre-write contents: read-first.
  always_ff @(posedge clk) begin
    if (issue)      s1_data_q <= mem[rd_ptr_q];
    if (s1_valid_q) s2_data_q <= s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[fifo_wr_q] <= s2_data_q;
      fifo_last[fifo_wr_q] <= s2_last_q;
    end
  end

  assign m_axis_tvalid = (fifo_cnt_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_data[fifo_rd_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid && fifo_last[fifo_rd_q];
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_memstream_ramb_reader.sv
// Self-checking bench: directed scenarios plus random windows and random
// backpressure, compared against a window-arithmetic model of the stream.
module tb_memstream_ramb_reader;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic [AW-1:0] cfg_base;
  logic [AW:0]   cfg_len;
  logic          cfg_loop;
  logic          start, stop;
  logic          busy, done;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;

  memstream_ramb_reader #(
    .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .MEM_INIT(""),
    .RAM_STYLE("auto"), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
    .start(start), .stop(stop), .busy(busy), .done(done),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  logic [DW-1:0] mm [DEPTH];
  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  int            got_edge [$];
  int            done_cnt = 0;
  int            done_edge = 0;
  logic          done_busy = 1'b0;
  logic          s_tvalid = 1'b0, s_busy = 1'b0;
  logic          prev_stall = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          rand_ready = 1'b0, ready_hold = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, then drive tready after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_tvalid = m_axis_tvalid;
    s_busy   = busy;
    if (aresetn) begin
      if (prev_stall) begin
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_tdata", m_axis_tdata, prev_data);
        check("stall_tlast", m_axis_tlast, prev_last);
      end
      check("fifo_no_overflow", dut.fifo_cnt_q <= FD, 1);
      if (m_axis_tvalid && m_axis_tready) begin
        got_data.push_back(m_axis_tdata);
        got_last.push_back(m_axis_tlast);
        got_edge.push_back(cyc + 1);
      end
      if (done) begin
        done_cnt++;
        done_edge = cyc;
        done_busy = busy;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_hold;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done_cnt != d0, 1);
  endtask

  // One-shot window; optional config write wr_at cycles after the start edge.
  task automatic run_oneshot(input string tag, input int base, input int len, input bit rnd,
                             input bit lat, input int wr_at, input int wr_addr,
                             input logic [DW-1:0] wr_val);
    logic [DW-1:0] exp_d [$];
    logic          exp_l [$];
    int idx0, d0, n;
    for (int i = 0; i < len; i++) begin
      exp_d.push_back(mm[(base + i) % DEPTH]);
      exp_l.push_back(i == len - 1);
    end
    idx0 = got_data.size();
    d0 = done_cnt;
    rand_ready = rnd;
    ready_hold = 1'b1;
    m_axis_tready = 1'b1;
    cfg_base = AW'(base);
    cfg_len = (AW+1)'(len);
    cfg_loop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (lat) begin
      tick(); tick(); tick();
      check({tag, "_tvalid_early"}, s_tvalid, 0);
      tick();
      check({tag, "_tvalid_at_3"}, s_tvalid, 1);
    end
    if (wr_at >= 0) begin
      repeat (wr_at) tick();
      cfg_we = 1'b1;
      cfg_addr = AW'(wr_addr);
      cfg_wdata = wr_val;
      tick();
      cfg_we = 1'b0;
      mm[wr_addr] = wr_val;
    end
    wait_done(tag, d0, 2000);
    tick(); tick();
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_done_busy"}, done_busy, 0);
    check({tag, "_busy_low"}, s_busy, 0);
    n = got_data.size() - idx0;
    check({tag, "_count"}, n, len);
    if (n > 0) check({tag, "_done_timing"}, done_edge, got_edge[got_data.size() - 1] + 1);
    for (int i = 0; i < n && i < len; i++) begin
      check({tag, "_data"}, got_data[idx0 + i], exp_d[i]);
      check({tag, "_last"}, got_last[idx0 + i], exp_l[i]);
      if (!rnd && i > 0) check({tag, "_gapless"}, got_edge[idx0 + i] - got_edge[idx0 + i - 1], 1);
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    int idx0, d0, n, b, l;
    aresetn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_base = '0; cfg_len = '0; cfg_loop = 1'b0; start = 1'b0; stop = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    tick(); tick();
    aresetn = 1'b1;
    tick();

    for (int k = 0; k < DEPTH; k++) begin
      cfg_we = 1'b1; cfg_addr = AW'(k); cfg_wdata = DW'(k); mm[k] = DW'(k);
      tick();
    end
    cfg_we = 1'b0;
    tick();

    run_oneshot("basic", 0, 8, 1'b0, 1'b1, -1, 0, '0);
    run_oneshot("wrap", DEPTH - 2, 4, 1'b0, 1'b0, -1, 0, '0);

    // Loop mode, stopped after ten beats.
    idx0 = got_data.size(); d0 = done_cnt;
    cfg_base = AW'(5); cfg_len = (AW+1)'(3); cfg_loop = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (got_data.size() - idx0 < 10 && n < 200) begin tick(); n++; end
    check("loop_ten_beats", got_data.size() - idx0 >= 10, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_done("loop", d0, 200);
    tick(); tick();
    check("loop_done_once", done_cnt - d0, 1);
    check("loop_busy_low", s_busy, 0);
    n = got_data.size() - idx0;
    check("loop_bounded", n >= 10 && n <= 10 + FD + 4, 1);
    for (int j = 0; j < n; j++) begin
      check("loop_data", got_data[idx0 + j], DW'(5 + (j % 3)));
      check("loop_last", got_last[idx0 + j], (j % 3) == 2);
      if (j > 0) check("loop_gapless", got_edge[idx0 + j] - got_edge[idx0 + j - 1], 1);
    end
    cfg_loop = 1'b0;

    run_oneshot("bp16", int'($urandom_range(0, DEPTH - 1)), 16, 1'b1, 1'b0, -1, 0, '0);

    // Write lands on the edge that reads address 23: old value, then new on the next pass.
    run_oneshot("rdfirst", 20, 8, 1'b0, 1'b0, 3, 23, 32'hDEAD);
    run_oneshot("rdnew", 20, 8, 1'b0, 1'b0, -1, 0, '0);

    // Asynchronous reset while a stalled beat is presented.
    ready_hold = 1'b0; m_axis_tready = 1'b0;
    cfg_base = '0; cfg_len = (AW+1)'(40); cfg_loop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!s_tvalid && n < 20) begin tick(); n++; end
    check("rst_mid_tvalid_up", s_tvalid, 1);
    tick(); tick();
    d0 = done_cnt;
    aresetn = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_tvalid", m_axis_tvalid, 0);
    check("rst_mid_tlast", m_axis_tlast, 0);
    check("rst_mid_tdata", m_axis_tdata, 0);
    ready_hold = 1'b1;
    tick(); tick();
    aresetn = 1'b1;
    tick(); tick(); tick();
    check("rst_mid_no_done", done_cnt, d0);
    run_oneshot("post_rst", 18, 8, 1'b0, 1'b0, -1, 0, '0);

    // Zero length start is ignored.
    d0 = done_cnt; idx0 = got_data.size();
    cfg_len = '0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("len0_busy", s_busy, 0);
      check("len0_tvalid", s_tvalid, 0);
    end
    check("len0_no_done", done_cnt, d0);
    check("len0_no_beats", got_data.size(), idx0);

    // Random content and windows under random backpressure.
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 3; w++) begin
        b = int'($urandom_range(0, DEPTH - 1));
        cfg_we = 1'b1; cfg_addr = AW'(b); cfg_wdata = DW'($urandom); mm[b] = cfg_wdata;
        tick();
      end
      cfg_we = 1'b0;
      b = int'($urandom_range(0, DEPTH - 1));
      l = int'($urandom_range(1, 20));
      run_oneshot("rand", b, l, 1'b1, 1'b0, -1, 0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
